// File: rtl/wb_data_select.sv
// wb_data_select: registered write-back data selector for the multicycle
// datapath. Picks one of NSRC sources (including a constant and a 1-bit ALU
// flag) for the register-file write data. The memory source waits on a
// memory-ready handshake, then is byte/halfword extracted and sign/zero
// extended. A captured value is held and announced with a one-cycle pulse.
module wb_data_select #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NSRC      = 8,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned FLAG_IDX  = 1,
  parameter int unsigned CONST_IDX = 4,
  parameter int unsigned CONST_VAL = 227,
  parameter int unsigned MEM_IDX   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SEL_W-1:0]      sel,
  input  logic [NSRC*WIDTH-1:0] src_flat,
  input  logic [WIDTH-1:0]      mem_data,
  input  logic                  mem_ready,
  input  logic [1:0]            load_size,
  input  logic                  load_signed,
  input  logic [1:0]            byte_off,
  input  logic                  flush,
  output logic [WIDTH-1:0]      wb_data,
  output logic                  wb_valid,
  output logic                  busy
);

  // Elaboration-time sanity checks on the parameter set.
  if (WIDTH < 32) begin : g_bad_width
    $error("wb_data_select: WIDTH must be at least 32");
  end
  if ((2 ** SEL_W) < NSRC) begin : g_bad_sel_w
    $error("wb_data_select: SEL_W too narrow for NSRC");
  end

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_WORD     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_BYTE     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } size_t;

  // Select codes at select width, so comparisons stay width-matched.
  localparam logic [SEL_W-1:0] FLAG_SEL  = SEL_W'(FLAG_IDX);
  localparam logic [SEL_W-1:0] CONST_SEL = SEL_W'(CONST_IDX);
  localparam logic [SEL_W-1:0] MEM_SEL   = SEL_W'(MEM_IDX);

  state_t           state, state_d;
  size_t            lat_size;
  logic             lat_signed;
  logic [1:0]       lat_off;

  logic [WIDTH-1:0] direct_val;
  logic [WIDTH-1:0] mem_ext;
  logic [WIDTH-1:0] cap_val;
  logic             capture;
  logic             take_load;
  logic [7:0]       mem_byte;
  logic [15:0]      mem_half;

  // Direct source mux: slot value, with flag and constant overrides.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    direct_val = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (sel == SEL_W'(i)) begin
        direct_val = src_flat[i*WIDTH +: WIDTH];
      end
    end
    if (sel == FLAG_SEL) begin
      direct_val = {{(WIDTH-1){1'b0}}, direct_val[0]};
    end
    if (sel == CONST_SEL) begin
      direct_val = WIDTH'(CONST_VAL);
    end
  end

  // Memory extraction: pick the byte or halfword lane, then extend.
  always_comb begin
    unique case (lat_off)
      2'd0:    mem_byte = mem_data[7:0];
      2'd1:    mem_byte = mem_data[15:8];
      2'd2:    mem_byte = mem_data[23:16];
      default: mem_byte = mem_data[31:24];
    endcase
    mem_half = lat_off[1] ? mem_data[31:16] : mem_data[15:0];
    case (lat_size)
      SZ_HALF: mem_ext = {{(WIDTH-16){lat_signed & mem_half[15]}}, mem_half};
      SZ_BYTE: mem_ext = {{(WIDTH-8){lat_signed & mem_byte[7]}}, mem_byte};
      default: mem_ext = mem_data;
    endcase
  end

  // Next-state and capture decision; flush beats a simultaneous mem_ready.
  always_comb begin
    state_d   = state;
    capture   = 1'b0;
    take_load = 1'b0;
    cap_val   = direct_val;
    case (state)
      IDLE: begin
        if (start) begin
          if (sel == MEM_SEL) begin
            take_load = 1'b1;
            state_d   = WAIT_MEM;
          end else begin
            capture = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          capture = 1'b1;
          cap_val = mem_ext;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Load attributes, latched when a memory capture is requested.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: these are plain control registers, not a memory array, so they
    // are reset like everything else and never power up as X into the mux.
    if (!reset) begin
      lat_size   <= SZ_WORD;
      lat_signed <= 1'b0;
      lat_off    <= 2'd0;
    end else if (take_load) begin
      lat_size   <= size_t'(load_size);
      lat_signed <= load_signed;
      lat_off    <= byte_off;
    end
  end

  // Write-back data holds between captures; valid pulses for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_data  <= '0;
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= capture;
      if (capture) begin
        wb_data <= cap_val;
      end
    end
  end

  assign busy = (state == WAIT_MEM);

endmodule

// File: tb/tb_wb_data_select.sv
// Directed bench for wb_data_select. A transaction-level model predicts
// wb_data / wb_valid / busy every cycle; literal checks pin the model.
// Instantiated with NSRC=6 so selects 6 and 7 are out of range.
module tb_wb_data_select;

  localparam int W  = 32;
  localparam int N  = 6;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [W-1:0]  src [N];
  logic [N*W-1:0] src_flat;
  logic [W-1:0]  mem_data = '0;
  logic          mem_ready = 1'b0;
  logic [1:0]    load_size = '0;
  logic          load_signed = 1'b0;
  logic [1:0]    byte_off = '0;
  logic          flush = 1'b0;
  logic [W-1:0]  wb_data;
  logic          wb_valid;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign src_flat[g*W +: W] = src[g];
  end

  wb_data_select #(
    .WIDTH(W), .NSRC(N), .SEL_W(SW), .FLAG_IDX(1),
    .CONST_IDX(4), .CONST_VAL(227), .MEM_IDX(5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel),
    .src_flat(src_flat), .mem_data(mem_data), .mem_ready(mem_ready),
    .load_size(load_size), .load_signed(load_signed), .byte_off(byte_off),
    .flush(flush), .wb_data(wb_data), .wb_valid(wb_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0] size;
    bit         sgn;
    logic [1:0] off;
  } load_t;

  load_t      pend[$];
  logic [W-1:0] m_data;
  logic       m_valid;

  function automatic logic [W-1:0] model_pick(input int s);
    if (s >= N) return '0;
    if (s == 1) return src[1] & 32'd1;
    if (s == 4) return 32'd227;
    return src[s];
  endfunction

  function automatic logic [W-1:0] model_extract(input load_t ld,
                                                 input logic [W-1:0] md);
    int bits;
    int sh;
    logic [W-1:0] mask;
    logic [W-1:0] v;
    case (ld.size)
      2'b01: begin bits = 16; sh = 16 * int'(ld.off[1]); end
      2'b10: begin bits = 8;  sh = 8 * int'(ld.off); end
      default: return md;
    endcase
    mask = (32'd1 << bits) - 32'd1;
    v = (md >> sh) & mask;
    if (ld.sgn && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      pend.delete();
    end else begin
      m_valid <= 1'b0;
      if (pend.size() != 0) begin
        if (flush) begin
          pend.delete();
        end else if (mem_ready) begin
          m_data  <= model_extract(pend[0], mem_data);
          m_valid <= 1'b1;
          pend.delete();
        end
      end else if (start) begin
        if (int'(sel) == 5) begin
          pend.push_back('{size: load_size, sgn: load_signed, off: byte_off});
        end else begin
          m_data  <= model_pick(int'(sel));
          m_valid <= 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_wb_data", wb_data, m_data);
      check("model_wb_valid", W'(wb_valid), W'(m_valid));
      check("model_busy", W'(busy), W'(pend.size() != 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input logic [SW-1:0] s, input logic [1:0] sz = 2'b00,
                          input logic sg = 1'b0, input logic [1:0] off = 2'b00);
    @(negedge clk);
    start = 1'b1; sel = s; load_size = sz; load_signed = sg; byte_off = off;
    @(negedge clk);
    start = 1'b0;
    sel = SW'($urandom); load_size = 2'($urandom);
    load_signed = 1'($urandom); byte_off = 2'($urandom);
  endtask

  // Called just after a memory start; mem_ready is sampled on the
  // delay-th edge after the start edge.
  task automatic mem_return(input int delay, input logic [W-1:0] md);
    for (int i = 0; i < delay - 1; i++) begin
      mem_ready = 1'b0;
      check("busy_wait", W'(busy), 32'd1);
      @(negedge clk);
    end
    mem_ready = 1'b1; mem_data = md;
    @(negedge clk);
    mem_ready = 1'b0; mem_data = $urandom;
  endtask

  initial begin
    for (int i = 0; i < N; i++) src[i] = $urandom;
    reset = 1'b0; start = 1'b1; mem_ready = 1'b1; sel = SW'($urandom);
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_data", wb_data, 32'd0);
      check("rst_valid", W'(wb_valid), 32'd0);
      check("rst_busy", W'(busy), 32'd0);
      sel = SW'($urandom);
      for (int i = 0; i < N; i++) src[i] = $urandom;
    end
    start = 1'b0; mem_ready = 1'b0; reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_data", wb_data, 32'd0);
      check("post_rst_valid", W'(wb_valid), 32'd0);
    end

    // Direct sources.
    src[2] = 32'hDEADBEEF;
    do_start(3'd2);
    check("sel2_data", wb_data, 32'hDEADBEEF);
    check("sel2_valid", W'(wb_valid), 32'd1);
    @(negedge clk);
    check("valid_once", W'(wb_valid), 32'd0);
    check("hold_data", wb_data, 32'hDEADBEEF);
    do_start(3'd4);
    check("const", wb_data, 32'd227);
    src[1] = 32'hFFFFFFFE;
    do_start(3'd1);
    check("flag0", wb_data, 32'd0);
    src[1] = 32'h00000003;
    do_start(3'd1);
    check("flag1", wb_data, 32'd1);

    // Memory byte, signed, three-cycle wait.
    do_start(3'd5, 2'b10, 1'b1, 2'd2);
    check("mem_busy", W'(busy), 32'd1);
    check("mem_hold", wb_data, 32'd1);
    mem_return(3, 32'h12803456);
    check("byte_s", wb_data, 32'hFFFFFF80);
    check("byte_s_valid", W'(wb_valid), 32'd1);
    check("byte_s_busy", W'(busy), 32'd0);

    // Memory byte, unsigned; mem_ready already high in the start cycle.
    mem_ready = 1'b1; mem_data = 32'h12803456;
    do_start(3'd5, 2'b10, 1'b0, 2'd2);
    check("ready_in_start", W'(wb_valid), 32'd0);
    check("ready_in_start_busy", W'(busy), 32'd1);
    mem_return(1, 32'h12803456);
    check("byte_u", wb_data, 32'h00000080);

    // Memory halfwords.
    do_start(3'd5, 2'b01, 1'b1, 2'd2);
    mem_return(2, 32'h80017FFF);
    check("half_hi_s", wb_data, 32'hFFFF8001);
    do_start(3'd5, 2'b01, 1'b1, 2'd0);
    mem_return(1, 32'h80017FFF);
    check("half_lo_s", wb_data, 32'h00007FFF);

    // Flush wins over mem_ready.
    do_start(3'd5, 2'b00, 1'b0, 2'd0);
    flush = 1'b1; mem_ready = 1'b1; mem_data = 32'hAAAA5555;
    @(negedge clk);
    flush = 1'b0; mem_ready = 1'b0;
    check("flush_valid", W'(wb_valid), 32'd0);
    check("flush_data", wb_data, 32'h00007FFF);
    check("flush_busy", W'(busy), 32'd0);

    // Start while busy is ignored.
    do_start(3'd5, 2'b11, 1'b1, 2'd1);
    do_start(3'd2);
    check("busy_start_valid", W'(wb_valid), 32'd0);
    check("busy_start_busy", W'(busy), 32'd1);
    mem_return(1, 32'hCAFEF00D);
    check("word_alt", wb_data, 32'hCAFEF00D);

    // Flush in IDLE has no effect.
    src[3] = 32'h13579BDF;
    flush = 1'b1;
    do_start(3'd3);
    flush = 1'b0;
    check("idle_flush", wb_data, 32'h13579BDF);

    // Reset while waiting on memory.
    do_start(3'd5, 2'b10, 1'b1, 2'd0);
    check("pre_rst_busy", W'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", W'(busy), 32'd0);
    check("midrst_data", wb_data, 32'd0);
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1; mem_data = 32'h000000FF;
    repeat (2) begin
      @(negedge clk);
      check("stale_ready_valid", W'(wb_valid), 32'd0);
      check("stale_ready_data", wb_data, 32'd0);
    end
    mem_ready = 1'b0;

    // Out-of-range selects.
    do_start(3'd2);
    check("pre_oor", wb_data, 32'hDEADBEEF);
    do_start(3'd7);
    check("sel7_data", wb_data, 32'd0);
    check("sel7_valid", W'(wb_valid), 32'd1);
    do_start(3'd2);
    do_start(3'd6);
    check("sel6_data", wb_data, 32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_data_select.md
# wb_data_select

Registered, parametrised write-back data selector for the multicycle datapath. It picks one of NSRC sources, including a constant and a 1-bit ALU flag, to produce the register-file write data. Memory-sourced values wait on a memory-ready handshake and are byte/halfword-extracted with sign or zero extension. The captured value is held stable for the register-file write and announced with a one-cycle valid pulse.

## Interface
Parameters:
- WIDTH, 32, data width (>= 32)
- NSRC, 8, number of selectable sources
- SEL_W, 3, select width (2**SEL_W >= NSRC)
- FLAG_IDX, 1, index whose source is bit 0 of its slot, zero-extended
- CONST_IDX, 4, index returning CONST_VAL
- CONST_VAL, 227, constant source value
- MEM_IDX, 5, index routed through the memory handshake and extraction path

Ports (one clock; reset asynchronous, active-low):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state
- start  in  1  request: capture a write-back value this cycle
- sel  in  SEL_W  source index, sampled with start
- src_flat  in  NSRC*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]; slots CONST_IDX and MEM_IDX are ignored
- mem_data  in  WIDTH  memory data register value
- mem_ready  in  1  memory data valid
- load_size  in  2  00 word, 01 half, 10 byte, 11 treated as word; sampled with start
- load_signed  in  1  1 sign-extend, 0 zero-extend; sampled with start
- byte_off  in  2  address low bits; sampled with start
- flush  in  1  abort a pending memory capture
- wb_data  out  WIDTH  registered write-back value
- wb_valid  out  1  one-cycle pulse: wb_data was updated
- busy  out  1  high while waiting on memory

## Operation
- States: IDLE and WAIT_MEM.
- IDLE, start=1, sel != MEM_IDX:
  - wb_data <= selected value at the next edge; wb_valid=1 for that one cycle; stay in IDLE.
- Selected value:
  - sel==FLAG_IDX gives {0, src bit0}.
  - sel==CONST_IDX gives CONST_VAL zero-extended.
  - sel >= NSRC gives 0.
  - Any other sel gives its src_flat slot.
- IDLE, start=1, sel==MEM_IDX:
  - Latch load_size, load_signed and byte_off; go to WAIT_MEM; busy=1 from the next cycle.
  - wb_data is unchanged.
  - mem_ready in the start cycle is ignored.
- WAIT_MEM, mem_ready=1, flush=0:
  - wb_data <= extracted value; wb_valid pulse; go to IDLE; busy=0.
- WAIT_MEM, flush=1: go to IDLE, no valid pulse, wb_data unchanged. flush wins over a simultaneous mem_ready.
- flush in IDLE has no effect.
- start while in WAIT_MEM is ignored.
- Extraction uses mem_data[31:0]:
  - Byte: byte lane byte_off.
  - Half: byte_off[1]=0 gives [15:0], byte_off[1]=1 gives [31:16]; byte_off[0] is ignored.
  - Word: mem_data unchanged.
  - Byte and half results are extended to WIDTH per the latched load_signed.
- wb_data holds its last value whenever no capture occurs.

## Timing
- Reset (reset=0, asynchronous): state IDLE, wb_data=0, wb_valid=0, busy=0. Reset asserted in WAIT_MEM discards the pending load.
- Non-memory latency: start at edge N gives wb_data/wb_valid at edge N+1.
- Memory latency: start at edge N; WAIT_MEM from N+1; mem_ready sampled at edge M >= N+1 gives wb_data/wb_valid after edge M, i.e. a minimum of 2 cycles.
- wb_valid is never high in two consecutive cycles for the same request.
- A new start is accepted in the cycle wb_valid is high.
- Inputs other than mem_ready and flush are sampled only at start.

## Test plan
- Reset: hold reset=0 with start=1 and random inputs -> wb_data=0, wb_valid=0, busy=0 throughout; release reset -> still 0 until the first start.
- Direct sources:
  - start, sel=2, slot2=0xDEADBEEF -> wb_data=0xDEADBEEF, wb_valid pulse next cycle.
  - sel=4 -> 227.
  - sel=1, slot1=0xFFFFFFFE -> 0; slot1=0x3 -> 1.
- Memory byte signed: start sel=5, load_size=10, signed=1, byte_off=2; mem_ready after 3 cycles with mem_data=0x1280_3456 -> busy high 3 cycles, then wb_data=0xFFFFFF80; same with signed=0 -> 0x00000080.
- Memory half: load_size=01, byte_off=2, signed=1, mem_data=0x8001_7FFF -> 0xFFFF8001; byte_off=0 -> 0x00007FFF.
- Flush and collisions: in WAIT_MEM drive flush=1 with mem_ready=1 -> no wb_valid, wb_data unchanged, IDLE next cycle; start while busy -> ignored.
- Reset mid-wait and out-of-range select:
  - Assert reset in WAIT_MEM -> busy=0, wb_data=0; a later mem_ready produces no pulse.
  - NSRC=6, sel=7 -> wb_data=0 with wb_valid pulse.
